// File: rtl/seg_glyph_pkg.sv
// Shared glyph codes, segment patterns and scroll-step frame table for the
// HAPPY scroller readback path.
package seg_glyph_pkg;

  // Active-low segment patterns, bit7 is the (always off) decimal point
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_Y     = 8'h91;

  typedef enum logic [2:0] {
    GLYPH_BLANK = 3'd0,
    GLYPH_H     = 3'd1,
    GLYPH_A     = 3'd2,
    GLYPH_P     = 3'd3,
    GLYPH_Y     = 3'd4,
    GLYPH_UNK   = 3'd7
  } glyph_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  localparam logic [3:0] STEP_NONE = 4'd15;
  localparam int         NUM_STEPS = 10;

  // Glyph string per scroll step, packed HEX4 (bits 14:12) down to HEX0 (bits 2:0)
  localparam logic [14:0] STEP_FRAME [NUM_STEPS] = '{
    {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK},
    {GLYPH_Y,     GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK},
    {GLYPH_P,     GLYPH_Y,     GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK},
    {GLYPH_P,     GLYPH_P,     GLYPH_Y,     GLYPH_BLANK, GLYPH_BLANK},
    {GLYPH_A,     GLYPH_P,     GLYPH_P,     GLYPH_Y,     GLYPH_BLANK},
    {GLYPH_H,     GLYPH_A,     GLYPH_P,     GLYPH_P,     GLYPH_Y    },
    {GLYPH_BLANK, GLYPH_H,     GLYPH_A,     GLYPH_P,     GLYPH_P    },
    {GLYPH_BLANK, GLYPH_BLANK, GLYPH_H,     GLYPH_A,     GLYPH_P    },
    {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_H,     GLYPH_A    },
    {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_H    }
  };

  // Next scroll step with 9 wrapping to 0
  function automatic logic [3:0] step_succ(input logic [3:0] s);
    return (s == 4'd9) ? 4'd0 : (s + 4'd1);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational lookup from one active-low segment code to a glyph code.
module seg_glyph_decode
  import seg_glyph_pkg::*;
(
  input  logic [7:0] seg,
  output glyph_e     glyph
);

  // Map the five legal patterns, everything else is unknown
  always_comb begin
    glyph = GLYPH_UNK;
    case (seg)
      SEG_BLANK: glyph = GLYPH_BLANK;
      SEG_H:     glyph = GLYPH_H;
      SEG_A:     glyph = GLYPH_A;
      SEG_P:     glyph = GLYPH_P;
      SEG_Y:     glyph = GLYPH_Y;
      default:   glyph = GLYPH_UNK;
    endcase
  end

endmodule

// File: rtl/seg_frame_decoder.sv
// Readback decoder for the five-digit HAPPY scroller: captures a frame,
// decodes the glyphs, recovers the scroll step and tracks lock.
module seg_frame_decoder
  import seg_glyph_pkg::*;
#(
  parameter int LOCK_FRAMES = 3,
  parameter int ERR_STICKY  = 0
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       FRAME_VALID,
  input  logic [7:0] HEX0,
  input  logic [7:0] HEX1,
  input  logic [7:0] HEX2,
  input  logic [7:0] HEX3,
  input  logic [7:0] HEX4,
  output logic [2:0] CHAR0,
  output logic [2:0] CHAR1,
  output logic [2:0] CHAR2,
  output logic [2:0] CHAR3,
  output logic [2:0] CHAR4,
  output logic [3:0] STEP_OUT,
  output logic       STEP_VALID,
  output logic       LOCKED,
  output logic       ERR
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

  logic [7:0]     hex_r [5];
  logic           s1_valid_r;
  glyph_e         glyph_s [5];
  logic [14:0]    frame_s;
  logic           any_unk_s;
  logic [9:0]     hit_s;
  logic [3:0]     step_s;
  logic           bad_s;
  logic           adv_s;
  logic [2:0]     char_r [5];
  logic [3:0]     step_out_r;
  logic           step_valid_r;
  lock_state_e    state_r;
  logic [3:0]     prev_r;
  logic [3:0]     cnt_r;
  logic           locked_r;
  logic           err_r;

  // Stage 1: capture the frame only when the writer flags it valid
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 5; i++) hex_r[i] <= SEG_BLANK;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= FRAME_VALID;
      if (FRAME_VALID) begin
        hex_r[0] <= HEX0;
        hex_r[1] <= HEX1;
        hex_r[2] <= HEX2;
        hex_r[3] <= HEX3;
        hex_r[4] <= HEX4;
      end
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_dec
    seg_glyph_decode u_dec (
      .seg   (hex_r[gi]),
      .glyph (glyph_s[gi])
    );
  end

  assign frame_s   = {glyph_s[4], glyph_s[3], glyph_s[2], glyph_s[1], glyph_s[0]};
  assign any_unk_s = (glyph_s[0] == GLYPH_UNK) || (glyph_s[1] == GLYPH_UNK) ||
                     (glyph_s[2] == GLYPH_UNK) || (glyph_s[3] == GLYPH_UNK) ||
                     (glyph_s[4] == GLYPH_UNK);

  // Compare the decoded frame against every step pattern in parallel
  always_comb begin
    hit_s = 10'd0;
    for (int i = 0; i < NUM_STEPS; i++) hit_s[i] = (frame_s == STEP_FRAME[i]);
  end

  // Turn the one-hot hit vector into a step number; no or multiple hits means no match
  always_comb begin
    step_s = STEP_NONE;
    if (any_unk_s) begin
      step_s = STEP_NONE;
    end else begin
      case (hit_s)
        10'b00_0000_0001: step_s = 4'd0;
        10'b00_0000_0010: step_s = 4'd1;
        10'b00_0000_0100: step_s = 4'd2;
        10'b00_0000_1000: step_s = 4'd3;
        10'b00_0001_0000: step_s = 4'd4;
        10'b00_0010_0000: step_s = 4'd5;
        10'b00_0100_0000: step_s = 4'd6;
        10'b00_1000_0000: step_s = 4'd7;
        10'b01_0000_0000: step_s = 4'd8;
        10'b10_0000_0000: step_s = 4'd9;
        default:          step_s = STEP_NONE;
      endcase
    end
  end

  assign bad_s = (step_s == STEP_NONE);
  assign adv_s = (step_s == step_succ(prev_r));

  // Stage 2: publish decoded glyphs and step together with a one-cycle strobe
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 5; i++) char_r[i] <= 3'd0;
      step_out_r   <= 4'd0;
      step_valid_r <= 1'b0;
    end else begin
      step_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        for (int i = 0; i < 5; i++) char_r[i] <= glyph_s[i];
        step_out_r <= step_s;
      end
    end
  end

  // Lock FSM and error flag, updated alongside each published frame
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      prev_r   <= 4'd0;
      cnt_r    <= 4'd0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (s1_valid_r) begin
      if (bad_s) begin
        state_r  <= ST_IDLE;
        cnt_r    <= 4'd0;
        locked_r <= 1'b0;
        err_r    <= 1'b1;
      end else begin
        err_r <= (ERR_STICKY != 0) ? err_r : 1'b0;
        case (state_r)
          ST_IDLE: begin
            prev_r   <= step_s;
            cnt_r    <= 4'd0;
            locked_r <= 1'b0;
            state_r  <= ST_TRACK;
          end
          ST_TRACK: begin
            prev_r <= step_s;
            if (step_s == prev_r) begin
              cnt_r <= cnt_r;
            end else if (adv_s) begin
              if ((cnt_r + 4'd1) >= LOCK_MAX) begin
                cnt_r    <= LOCK_MAX;
                locked_r <= 1'b1;
                state_r  <= ST_LOCKED;
              end else begin
                cnt_r <= cnt_r + 4'd1;
              end
            end else begin
              cnt_r <= 4'd0;
            end
          end
          ST_LOCKED: begin
            prev_r <= step_s;
            if (!((step_s == prev_r) || adv_s)) begin
              locked_r <= 1'b0;
              cnt_r    <= 4'd0;
              state_r  <= ST_TRACK;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            locked_r <= 1'b0;
          end
        endcase
      end
    end else begin
      err_r <= (ERR_STICKY != 0) ? err_r : 1'b0;
    end
  end

  assign CHAR0      = char_r[0];
  assign CHAR1      = char_r[1];
  assign CHAR2      = char_r[2];
  assign CHAR3      = char_r[3];
  assign CHAR4      = char_r[4];
  assign STEP_OUT   = step_out_r;
  assign STEP_VALID = step_valid_r;
  assign LOCKED     = locked_r;
  assign ERR        = err_r;

endmodule
